// File: rtl/tx_prbs_gen.sv
// Serial TX data source: PRBS7/9/15/31, clock pattern or fixed pattern, one bit per clock.
// Define TX_ERR_INJECT_EN to build single-bit error injection with a saturating error counter.
module tx_prbs_gen #(
  parameter logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF,
  parameter int unsigned PAT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic                         seed_load,
  input  logic [30:0]                  seed,
  input  logic [PAT_WIDTH-1:0]         pat,
  input  logic [$clog2(PAT_WIDTH)-1:0] pat_len,
  output logic                         out,
  output logic                         lockup_err,
  input  logic                         err_inject,
  output logic [15:0]                  err_count
);

  localparam int unsigned IW = $clog2(PAT_WIDTH);

  typedef enum logic [1:0] {
    SRC_PRBS,
    SRC_CLOCK,
    SRC_PATTERN
  } src_e;

  logic [30:0]   s_q, s_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    mode_q;
  logic          out_q, out_d;
  logic          lockup_q, lockup_d;
  logic          emit;
  logic          flip;

  src_e          src;
  logic [4:0]    msb;
  logic [4:0]    tap;
  logic [30:0]   mask;
  logic          fb;

  // Polynomial selection; modes 6 and 7 fall through to PRBS7.
  always_comb begin
    src = SRC_PRBS;
    msb = 5'd6;
    tap = 5'd5;
    case (mode)
      3'd1:    begin msb = 5'd8;  tap = 5'd4;  end
      3'd2:    begin msb = 5'd14; tap = 5'd13; end
      3'd3:    begin msb = 5'd30; tap = 5'd27; end
      3'd4:    src = SRC_CLOCK;
      3'd5:    src = SRC_PATTERN;
      default: ;
    endcase
  end

  assign mask = 31'h7FFF_FFFF >> (5'd30 - msb);
  assign fb   = s_q[msb] ^ s_q[tap];

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    s_d      = s_q;
    idx_d    = idx_q;
    out_d    = out_q;
    lockup_d = lockup_q;
    emit     = 1'b0;
    if (seed_load) begin
      s_d   = ((seed & mask) == '0) ? mask : (seed & mask);
      idx_d = '0;
    end else if (mode != mode_q) begin
      s_d   = DEFAULT_SEED & mask;
      idx_d = '0;
    end else if (src == SRC_PRBS && (s_q & mask) == '0) begin
      s_d      = mask;
      lockup_d = 1'b1;
    end else if (en) begin
      emit = 1'b1;
      case (src)
        SRC_PRBS: begin
          out_d = s_q[msb];
          s_d   = {s_q[29:0], fb} & mask;
        end
        SRC_CLOCK: out_d = ~out_q;
        default: begin
          out_d = pat[idx_q];
          idx_d = (idx_q >= pat_len) ? '0 : idx_q + IW'(1);
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= DEFAULT_SEED;
      idx_q    <= '0;
      mode_q   <= '0;
      out_q    <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      idx_q    <= idx_d;
      mode_q   <= mode;
      out_q    <= out_d ^ flip;
      lockup_q <= lockup_d;
    end
  end

`ifdef TX_ERR_INJECT_EN
  logic        pend_q;
  logic [15:0] cnt_q;

  // Pulses arriving before the next emitted bit merge into one pending inversion.
  assign flip = emit & pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~emit) | err_inject;
      if (flip && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_err_inject;

  assign unused_err_inject = err_inject;
  assign flip              = 1'b0;
  assign err_count         = '0;
`endif

  assign out        = out_q;
  assign lockup_err = lockup_q;

endmodule

// File: doc/tx_prbs_gen.md
# tx_prbs_gen

Transmit data source for the link emulator. Produces one serial bit per clock from a selectable PRBS polynomial or a programmable fixed pattern, and drives the single-bit `in` port of the TX FFE stage directly downstream. Supports seed loading, automatic recovery from the all-zero LFSR state and, optionally, single-bit error injection for checker validation.

## Interface

Parameters:
- `DEFAULT_SEED`, 31'h7FFFFFFF: LFSR state after reset; must be nonzero in the low 7 bits.
- `PAT_WIDTH`, 16: width of the fixed-pattern register.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  advance generator one bit when high; hold all state when low.
- `mode`  in  3  0 PRBS7, 1 PRBS9, 2 PRBS15, 3 PRBS31, 4 clock (1010…), 5 fixed pattern, 6–7 treated as PRBS7.
- `seed_load`  in  1  load `seed` into LFSR.
- `seed`  in  31  seed value; low N bits used for PRBS-N.
- `pat`  in  PAT_WIDTH  fixed pattern, bit 0 sent first.
- `pat_len`  in  $clog2(PAT_WIDTH)  pattern length minus one.
- `out`  out  1  serial bit to TX FFE `in`.
- `lockup_err`  out  1  sticky flag: all-zero LFSR state was detected.
- `err_inject`  in  1  invert next emitted bit (only with TX_ERR_INJECT_EN).
- `err_count`  out  16  saturating count of injected errors (only with TX_ERR_INJECT_EN).

## Operation

- LFSR: 31-bit register `s`; active length N from mode. Fibonacci form: `fb = s[N-1] ^ s[T-1]`, next state `{s[N-2:0], fb}` over the low N bits; bits above N are don't-care and held at 0.
- Taps (N,T): PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS31 (31,28).
- PRBS modes: on an `en` cycle, `out <= s[N-1]`, LFSR advances.
- Mode 4: on `en`, `out <= ~out`.
- Mode 5: on `en`, `out <= pat[idx]`; `idx` increments and wraps to 0 after `idx == pat_len`.
- Seed: on `seed_load`, LFSR loads `seed` masked to N bits. If the masked value is zero, all-ones (N bits) is loaded instead. `idx` clears.
- Mode change: a cycle in which `mode` differs from its registered copy reloads the LFSR with `DEFAULT_SEED` masked to N, clears `idx`, and does not advance. `out` holds.
- Lockup: if the low N bits of `s` are zero in a PRBS mode, the next cycle reloads all-ones and sets `lockup_err`. `lockup_err` clears only on `rst`.
- Priority per cycle: `rst` > `seed_load` > mode change > lockup recovery > `en` advance.

## Timing

- Reset values: `out` 0, `lockup_err` 0, `err_count` 0, `s` = `DEFAULT_SEED`, `idx` 0, registered mode 0.
- `out` is registered; a state bit appears on `out` one clock after the `en` cycle that consumes it.
- `en` low: `out`, `s`, `idx` hold exactly. `err_inject` is still latched as pending.
- `seed_load` with `en` high: load wins, no advance, `out` holds. First seeded bit appears on `out` after the following `en` cycle.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous). The first post-reset `en` cycle emits `DEFAULT_SEED[N-1]`.
- `pat_len` changed while `idx > pat_len`: `idx` wraps to 0 on the next `en` cycle.

## Configuration

- `TX_ERR_INJECT_EN` defined:
  - An `err_inject` pulse sets a pending flag.
  - The next `en` cycle emits the inverted bit and clears pending.
  - `err_count` increments, saturating at 16'hFFFF.
  - Multiple pulses before that `en` cycle count as one.
- Undefined: `err_inject` is ignored, `err_count` is tied to 0, and no pending logic is synthesized.

## Test plan

- Reset, mode 0, `en` held high:
  - bits 1–7 on `out` are 1 and bit 8 is 0;
  - sequence repeats with period 127 and contains 64 ones per period.
- Modes 1, 2, 3 from reset seed: measured periods are 511, 32767 and 2^31−1.
  - PRBS31 is checked via a model comparison over 10^5 bits.
- `seed_load` with `seed` = 0 in mode 0: LFSR loads 7'h7F, stream matches the post-reset stream, and `lockup_err` stays 0.
  - Forcing `s` to 0 via backdoor sets `lockup_err` and the stream resumes from all-ones.
- Mode 5, `pat` = 16'h00F3, `pat_len` = 7: `out` repeats 1,1,0,0,1,1,1,1 and `en` gaps hold `out` unchanged.
- Mode switch 0→4 mid-stream: one non-advancing cycle, then `out` toggles every `en` cycle.
  - Asserting `rst` mid-toggle forces `out` to 0 within the same cycle.
- With `TX_ERR_INJECT_EN`, mode 0: an `err_inject` pulse inverts exactly one bit versus the model and `err_count` reads 1.
  - Three pulses during `en` low still give a single inversion.
